// File: rtl/spfilt_pkg.sv
// spfilt_pkg: shared types and constants for the speech synthesis filter
// sequencer.
//   NSECT     number of cascaded second-order sections
//   DATA_W    sample / delay-state width (signed)
//   COEF_W    sign-magnitude coefficient width (bit 9 = sign, Q9 magnitude)
//   ACC_W     section accumulator width (signed)
//   state_e   sequencer states
//   sat16()   clamp an accumulator value into the signed 16-bit range
package spfilt_pkg;

  localparam int NSECT  = 6;
  localparam int DATA_W = 16;
  localparam int COEF_W = 10;
  localparam int ACC_W  = 19;
  localparam int SECT_W = 3;
  localparam int YIDX_W = SECT_W + 1;

  localparam logic [SECT_W-1:0] LAST_SECT = SECT_W'(NSECT - 1);

  localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = 19'sd32767;
  localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = -19'sd32768;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START1 = 3'd2,
    ST_WAIT1  = 3'd3,
    ST_START2 = 3'd4,
    ST_WAIT2  = 3'd5,
    ST_UPDATE = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > ACC_SAT_MAX) begin
      r = 16'sh7FFF;
    end else if (v < ACC_SAT_MIN) begin
      r = 16'sh8000;
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/spfilt_acc.sv
// spfilt_acc: 19-bit signed section accumulator.
//   clk, rst    clock and synchronous active-high reset
//   load_i      acc <= sign-extended load_val_i
//   add2_i      acc += 2 * add_val_i
//   add_i       acc += add_val_i
//   load_val_i  section input sample
//   add_val_i   multiplier product
//   sat_o       accumulator clamped to the signed 16-bit range
// The three controls are mutually exclusive; load has priority.
module spfilt_acc
  import spfilt_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic                     add_i,
  input  logic                     add2_i,
  input  logic signed [DATA_W-1:0] load_val_i,
  input  logic signed [DATA_W-1:0] add_val_i,
  output logic signed [DATA_W-1:0] sat_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] ext_s;
  logic signed [ACC_W-1:0] dbl_s;

  // Next accumulator value from the selected operation.
  always_comb begin
    ext_s = {{(ACC_W - DATA_W){add_val_i[DATA_W-1]}}, add_val_i};
    dbl_s = {ext_s[ACC_W-2:0], 1'b0};
    if (load_i) begin
      acc_d = {{(ACC_W - DATA_W){load_val_i[DATA_W-1]}}, load_val_i};
    end else if (add2_i) begin
      acc_d = acc_q + dbl_s;
    end else if (add_i) begin
      acc_d = acc_q + ext_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sat_o = sat16(acc_q);

endmodule

// File: rtl/spfilt_seq.sv
// spfilt_seq: time-shares one external SPMUL across NSECT cascaded
// second-order sections. Per section: y = sat16(x + 2*a1*y1 + a2*y2).
//   clk, rst     clock and synchronous active-high reset
//   sample_stb   accept sample_in (ignored and flagged while busy)
//   sample_in    signed excitation sample
//   coefs        {a2,a1} per section, section 0 in the LSBs
//   flush        clear all delay states (deferred to DONE while busy)
//   busy         sample in progress
//   out_stb      one-cycle strobe, sample_out valid
//   sample_out   filtered sample, held until the next out_stb
//   overrun      sticky: a sample arrived while busy
//   mul_start    SPMUL start pulse
//   mul_sig      SPMUL signal operand (held until completion)
//   mul_coef     SPMUL coefficient operand (held until completion)
//   mul_result   SPMUL product
//   mul_done     SPMUL completion flag, acted on only at its rising edge
module spfilt_seq
  import spfilt_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_stb,
  input  logic signed [DATA_W-1:0]      sample_in,
  input  logic [2*COEF_W*NSECT-1:0]     coefs,
  input  logic                          flush,
  output logic                          busy,
  output logic                          out_stb,
  output logic signed [DATA_W-1:0]      sample_out,
  output logic                          overrun,
  output logic                          mul_start,
  output logic signed [DATA_W-1:0]      mul_sig,
  output logic [COEF_W-1:0]             mul_coef,
  input  logic signed [DATA_W-1:0]      mul_result,
  input  logic                          mul_done
);

  state_e                   state_q;
  logic [SECT_W-1:0]        k_q;
  logic signed [DATA_W-1:0] x_q;
  // Delay states: even index = y1 of section k, odd index = y2.
  logic signed [DATA_W-1:0] y_q [2*NSECT];
  logic                     busy_q;
  logic                     out_stb_q;
  logic signed [DATA_W-1:0] sample_out_q;
  logic                     overrun_q;
  logic                     mul_start_q;
  logic signed [DATA_W-1:0] mul_sig_q;
  logic [COEF_W-1:0]        mul_coef_q;
  logic                     done_prev_q;
  logic                     flush_pend_q;

  logic [COEF_W-1:0]        a1_arr_s [NSECT];
  logic [COEF_W-1:0]        a2_arr_s [NSECT];
  logic [COEF_W-1:0]        a1_s;
  logic [COEF_W-1:0]        a2_s;
  logic [YIDX_W-1:0]        y1_idx_s;
  logic [YIDX_W-1:0]        y2_idx_s;
  logic                     done_rise_s;
  logic                     acc_load_s;
  logic                     acc_add_s;
  logic                     acc_add2_s;
  logic signed [DATA_W-1:0] acc_sat_s;

  // Unpack the per-section coefficient pairs.
  always_comb begin
    for (int i = 0; i < NSECT; i++) begin
      a1_arr_s[i] = coefs[i*2*COEF_W +: COEF_W];
      a2_arr_s[i] = coefs[i*2*COEF_W + COEF_W +: COEF_W];
    end
  end

  // Operand selection and accumulator control for the current section.
  always_comb begin
    a1_s        = a1_arr_s[k_q];
    a2_s        = a2_arr_s[k_q];
    y1_idx_s    = {k_q, 1'b0};
    y2_idx_s    = {k_q, 1'b1};
    // A done level left high from the previous product must not count.
    done_rise_s = mul_done & ~done_prev_q;
    acc_load_s  = (state_q == ST_LOAD);
    acc_add2_s  = (state_q == ST_WAIT1) && done_rise_s;
    acc_add_s   = (state_q == ST_WAIT2) && done_rise_s;
  end

  spfilt_acc u_acc (
    .clk        (clk),
    .rst        (rst),
    .load_i     (acc_load_s),
    .add_i      (acc_add_s),
    .add2_i     (acc_add2_s),
    .load_val_i (x_q),
    .add_val_i  (mul_result),
    .sat_o      (acc_sat_s)
  );

  // Sequencer FSM with registered outputs and delay-state updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      x_q          <= '0;
      busy_q       <= 1'b0;
      out_stb_q    <= 1'b0;
      sample_out_q <= '0;
      overrun_q    <= 1'b0;
      mul_start_q  <= 1'b0;
      mul_sig_q    <= '0;
      mul_coef_q   <= '0;
      done_prev_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      for (int i = 0; i < 2*NSECT; i++) y_q[i] <= '0;
    end else begin
      out_stb_q   <= 1'b0;
      mul_start_q <= 1'b0;
      done_prev_q <= mul_done;
      if (sample_stb && busy_q) overrun_q <= 1'b1;
      if (flush && busy_q) flush_pend_q <= 1'b1;

      case (state_q)
        // IDLE and DONE behave identically: a new sample starts at once.
        ST_IDLE, ST_DONE: begin
          if (flush) begin
            for (int i = 0; i < 2*NSECT; i++) y_q[i] <= '0;
          end
          if (sample_stb) begin
            x_q     <= sample_in;
            k_q     <= '0;
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          mul_start_q <= 1'b1;
          mul_sig_q   <= y_q[y1_idx_s];
          mul_coef_q  <= a1_s;
          state_q     <= ST_START1;
        end
        ST_START1: begin
          state_q <= ST_WAIT1;
        end
        ST_WAIT1: begin
          if (done_rise_s) begin
            mul_start_q <= 1'b1;
            mul_sig_q   <= y_q[y2_idx_s];
            mul_coef_q  <= a2_s;
            state_q     <= ST_START2;
          end
        end
        ST_START2: begin
          state_q <= ST_WAIT2;
        end
        ST_WAIT2: begin
          if (done_rise_s) state_q <= ST_UPDATE;
        end
        ST_UPDATE: begin
          y_q[y2_idx_s] <= y_q[y1_idx_s];
          y_q[y1_idx_s] <= acc_sat_s;
          x_q           <= acc_sat_s;
          if (k_q == LAST_SECT) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            out_stb_q    <= 1'b1;
            sample_out_q <= acc_sat_s;
            // A deferred flush lands after this sample's output is formed.
            if (flush_pend_q || flush) begin
              for (int i = 0; i < 2*NSECT; i++) y_q[i] <= '0;
              flush_pend_q <= 1'b0;
            end
          end else begin
            k_q     <= k_q + SECT_W'(1);
            state_q <= ST_LOAD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign out_stb    = out_stb_q;
  assign sample_out = sample_out_q;
  assign overrun    = overrun_q;
  assign mul_start  = mul_start_q;
  assign mul_sig    = mul_sig_q;
  assign mul_coef   = mul_coef_q;

endmodule

// File: tb/tb_spfilt_seq.sv
// tb_spfilt_seq: scoreboard bench for spfilt_seq. A behavioural SPMUL
// answers each start after a programmable latency; a reference model
// computes each filtered sample directly from the section equations.
module tb_spfilt_seq;

  localparam int NS = 6;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_stb;
  logic signed [15:0] sample_in;
  logic [119:0]       coefs;
  logic               flush;
  logic               busy;
  logic               out_stb;
  logic signed [15:0] sample_out;
  logic               overrun;
  logic               mul_start;
  logic signed [15:0] mul_sig;
  logic [9:0]         mul_coef;
  logic signed [15:0] mul_result;
  logic               mul_done;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   lat = 11;
  int   drop_dly = 0;
  logic mul_abort = 1'b0;
  exp_t exp_q[$];
  int   my1 [NS];
  int   my2 [NS];

  spfilt_seq dut (
    .clk        (clk),
    .rst        (rst),
    .sample_stb (sample_stb),
    .sample_in  (sample_in),
    .coefs      (coefs),
    .flush      (flush),
    .busy       (busy),
    .out_stb    (out_stb),
    .sample_out (sample_out),
    .overrun    (overrun),
    .mul_start  (mul_start),
    .mul_sig    (mul_sig),
    .mul_coef   (mul_coef),
    .mul_result (mul_result),
    .mul_done   (mul_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Sign-magnitude Q9 product, truncated toward zero.
  function automatic int spmul(input int sig, input logic [9:0] c);
    int p;
    p = (sig * int'(c[8:0])) / 512;
    return c[9] ? -p : p;
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  function automatic logic [9:0] cf(input int k, input int which);
    return coefs[k*20 + which*10 +: 10];
  endfunction

  function automatic int ref_sample(input int s);
    int x;
    int y;
    x = s;
    for (int k = 0; k < NS; k++) begin
      y = sat(x + 2 * spmul(my1[k], cf(k, 0)) + spmul(my2[k], cf(k, 1)));
      my2[k] = my1[k];
      my1[k] = y;
      x = y;
    end
    return x;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NS; k++) begin
      my1[k] = 0;
      my2[k] = 0;
    end
  endtask

  // Behavioural SPMUL: completes after 'lat' cycles; optionally leaves the
  // previous done level high for 'drop_dly' cycles into the new operation.
  initial begin
    int p;
    logic [15:0] cap_sig;
    logic [9:0]  cap_coef;
    mul_done   = 1'b0;
    mul_result = '0;
    forever begin
      @(negedge clk);
      if (mul_start === 1'b1) begin
        mul_abort = 1'b0;
        cap_sig   = mul_sig;
        cap_coef  = mul_coef;
        p = spmul(int'(mul_sig), mul_coef);
        if (drop_dly == 0) mul_done = 1'b0;
        for (int i = 1; i <= lat; i++) begin
          @(negedge clk);
          if (i == drop_dly) mul_done = 1'b0;
          if (i == lat) begin
            if (!mul_abort) begin
              chk("mul_sig_hold", int'(mul_sig), int'($signed(cap_sig)));
              chk("mul_coef_hold", int'(mul_coef), int'(cap_coef));
            end
            mul_result = 16'(p);
            mul_done   = 1'b1;
          end
        end
      end
    end
  end

  // Output monitor: every out_stb must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_stb", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sample_out", int'(sample_out), e.val);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  // Issue a sample at the current negedge; returns one cycle later.
  task automatic send(input int s);
    exp_t e;
    e.val = ref_sample(s);
    e.cyc = cyc + 1 + NS * (4 + 2 * lat);
    exp_q.push_back(e);
    sample_in  = 16'(s);
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
  endtask

  // Wait (bounded) until out_stb is presented; returns in that cycle.
  task automatic wait_out();
    int n;
    n = 0;
    while (out_stb !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("out_timeout", 0, 1);
  endtask

  task automatic run(input int s);
    send(s);
    wait_out();
    @(negedge clk);
  endtask

  task automatic set_all(input logic [9:0] a1, input logic [9:0] a2);
    for (int k = 0; k < NS; k++) begin
      coefs[k*20 +: 10]      = a1;
      coefs[k*20 + 10 +: 10] = a2;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_out_stb"}, int'(out_stb), 0);
    chk({tag, "_sample_out"}, int'(sample_out), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_mul_start"}, int'(mul_start), 0);
    chk({tag, "_mul_sig"}, int'(mul_sig), 0);
    chk({tag, "_mul_coef"}, int'(mul_coef), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1; sample_stb = 1'b0; sample_in = '0; flush = 1'b0; coefs = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Pass-through with zero coefficients, nominal latency.
    run(1000);

    // Section-0 integrator, deferred flush, idle flush.
    coefs = '0;
    coefs[9:0] = 10'h100;
    run(1000); run(0); run(0); run(0);
    send(0);
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_out();
    model_clear();
    @(negedge clk);
    run(0);
    run(500);
    do_flush();
    run(0);

    // Positive saturation.
    set_all(10'h1FF, 10'h000);
    run(32767); run(32767);
    run(-32768); run(-32768);

    // Negative coefficient, most negative input.
    do_flush();
    set_all(10'h2FF, 10'h000);
    run(-32768);
    run(-32768);
    chk("overrun_idle", int'(overrun), 0);

    // Overrun mid-sample, then back-to-back acceptance in DONE.
    set_all(10'h0C3, 10'h3A0);
    send(1234);
    repeat (40) @(negedge clk);
    sample_in  = 16'sd999;
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    wait_out();
    send(777);
    wait_out();
    send(-5);
    wait_out();
    @(negedge clk);

    // Randomised coefficients, samples, latencies and done behaviour.
    for (int i = 0; i < 12; i++) begin
      coefs    = 120'({$urandom, $urandom, $urandom, $urandom});
      lat      = int'($urandom_range(4, 12));
      drop_dly = ($urandom_range(0, 1) == 1) ? 2 : 0;
      s = int'($signed(16'($urandom)));
      send(s);
      wait_out();
      if ($urandom_range(0, 1) == 1) begin
        s = int'($signed(16'($urandom)));
        send(s);
        wait_out();
      end
      @(negedge clk);
    end

    // Reset during WAIT2 of section 3.
    lat = 11;
    drop_dly = 0;
    set_all(10'h100, 10'h000);
    send(2000);
    repeat (97) @(negedge clk);
    chk("busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    mul_abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    chk_reset_vals("midrst");
    repeat (30) @(negedge clk);
    run(3000);
    run(0);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
